// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared constants, datapath types and enums for the pooling stage
package cnn_pkg;

    localparam int DW    = 16;
    localparam int MAX_W = 32;

    typedef logic signed [DW-1:0] pix_t;
    typedef logic signed [DW+1:0] acc_t;

    typedef enum logic {
        POOL_MAX = 1'b0,
        POOL_AVG = 1'b1
    } pool_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } pool_state_e;

endpackage

// File: rtl/pool_stream_2x2_if.sv
// rtl/pool_stream_2x2_if.sv - control, pixel-in and pooled-out signals of the pooling stage
interface pool_stream_2x2_if #(
    parameter int DW = 16,
    parameter int AW = 8
);

    logic                 start;
    logic [15:0]          map_size;
    logic                 mode;
    logic                 in_valid;
    logic signed [DW-1:0] in_data;
    logic                 busy;
    logic                 out_valid;
    logic signed [DW-1:0] out_data;
    logic [AW-1:0]        out_addr;
    logic                 done;

    modport master (
        output start, map_size, mode, in_valid, in_data,
        input  busy, out_valid, out_data, out_addr, done
    );

    modport slave (
        input  start, map_size, mode, in_valid, in_data,
        output busy, out_valid, out_data, out_addr, done
    );

endinterface

// File: rtl/pool_line_buf.sv
// rtl/pool_line_buf.sv - half-row buffer of partial 2x2 results, sync write / comb read
module pool_line_buf #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int W     = 18
) (
    input  logic                clk,
    input  logic                we,
    input  logic [AW-1:0]       addr,
    input  logic signed [W-1:0] wdata,
    output logic signed [W-1:0] rdata
);

    logic signed [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/pool_stream_2x2.sv
// rtl/pool_stream_2x2.sv - on-the-fly 2x2 stride-2 max/avg pooling of a raster pixel stream
module pool_stream_2x2 #(
    parameter int MAX_W = cnn_pkg::MAX_W,
    parameter int DW    = cnn_pkg::DW,
    parameter int AW    = 8
) (
    input  logic clk,
    input  logic reset,
    pool_stream_2x2_if.slave bus
);

    import cnn_pkg::*;

    localparam int ACC_W = DW + 2;
    localparam int LB_D  = MAX_W / 2;
    localparam int LB_AW = (LB_D > 1) ? $clog2(LB_D) : 1;

    pool_state_e state;
    pool_mode_e  mode_q;
    logic [15:0] size_q;
    logic [15:0] row;
    logic [15:0] col;

    logic signed [ACC_W-1:0] h;
    logic signed [ACC_W-1:0] pix;
    logic signed [ACC_W-1:0] lb_rd;
    logic signed [ACC_W-1:0] lb_wd;
    logic signed [ACC_W-1:0] max3;
    logic signed [ACC_W-1:0] sum3;
    logic signed [ACC_W-1:0] result;
    logic [LB_AW-1:0]        lb_idx;
    logic                    lb_we;
    logic                    accept;
    logic                    col_last;
    logic                    row_last;

    assign pix      = {{2{bus.in_data[DW-1]}}, bus.in_data};
    assign accept   = (state == ST_RUN) && bus.in_valid && (size_q != 16'd0);
    assign col_last = (col == size_q - 16'd1);
    assign row_last = (row == size_q - 16'd1);
    assign lb_idx   = col[LB_AW:1];

    // Top row of each block parks its pair result; the bottom row folds it back in.
    assign lb_we = accept && col[0] && !row[0];
    assign lb_wd = (mode_q == POOL_MAX) ? ((h > pix) ? h : pix) : (h + pix);

    always_comb begin
        max3 = lb_rd;
        if (h > max3) begin
            max3 = h;
        end
        if (pix > max3) begin
            max3 = pix;
        end
        sum3   = lb_rd + h + pix;
        result = (mode_q == POOL_MAX) ? max3 : (sum3 >>> 2);
    end

    pool_line_buf #(
        .DEPTH (LB_D),
        .AW    (LB_AW),
        .W     (ACC_W)
    ) u_line_buf (
        .clk   (clk),
        .we    (lb_we),
        .addr  (lb_idx),
        .wdata (lb_wd),
        .rdata (lb_rd)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= ST_IDLE;
            mode_q        <= POOL_MAX;
            size_q        <= 16'd0;
            row           <= 16'd0;
            col           <= 16'd0;
            h             <= '0;
            bus.busy      <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_addr  <= '0;
            bus.done      <= 1'b0;
        end else begin
            bus.out_valid <= 1'b0;
            bus.done      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        size_q   <= bus.map_size;
                        mode_q   <= pool_mode_e'(bus.mode);
                        row      <= 16'd0;
                        col      <= 16'd0;
                        state    <= ST_RUN;
                        bus.busy <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (size_q == 16'd0) begin
                        state    <= ST_FIN;
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                    end else if (accept) begin
                        if (!col[0]) begin
                            h <= pix;
                        end
                        if (col[0] && row[0]) begin
                            bus.out_valid <= 1'b1;
                            bus.out_data  <= result[DW-1:0];
                            bus.out_addr  <= AW'((row >> 1) * (size_q >> 1) + (col >> 1));
                        end
                        if (col_last) begin
                            col <= 16'd0;
                            row <= row + 16'd1;
                            if (row_last) begin
                                state    <= ST_FIN;
                                bus.busy <= 1'b0;
                                bus.done <= 1'b1;
                            end
                        end else begin
                            col <= col + 16'd1;
                        end
                    end
                end
                ST_FIN: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
